// File: rtl/conv1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv1_pkg: shared widths and FSM encoding for the 3x3 conv MAC        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package conv1_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC   = 8;

  // Nine products of 2*DATA_W bits plus a shifted bias need 4 guard bits.
  function automatic int acc_width(input int data_w);
    return 2 * data_w + 4;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_DATA_W);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv1_sat_relu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv1_sat_relu: rescale accumulator, ReLU, clamp to positive max      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module conv1_sat_relu
  import conv1_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic        [DATA_W-1:0] o_data
);

  localparam logic signed [ACC_W-1:0] C_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic signed [ACC_W-1:0] w_shift;

  always_comb begin
    w_shift = i_acc >>> FRAC;
    if (w_shift[ACC_W-1]) begin
      o_data = '0;
    end else if (w_shift > C_MAX) begin
      o_data = C_MAX[DATA_W-1:0];
    end else begin
      o_data = w_shift[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv1_mac3x3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv1_mac3x3: 3x3 convolution with bias, ReLU and saturation          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module conv1_mac3x3
  import conv1_pkg::*;
#(
  parameter int W      = 224,
  parameter int H      = 224,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9*DATA_W-1:0]   win_in,
  input  logic                  win_valid,
  input  logic                  w_wr,
  input  logic [DATA_W-1:0]     w_data,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  ready,
  output logic                  frame_done
);

  localparam int ACC_W  = acc_width(DATA_W);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ROW_W  = 2 * DATA_W + 2;
  localparam int COL_W  = (W > 1) ? $clog2(W) : 1;
  localparam int ROWC_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [COL_W-1:0]  C_COL_LAST = COL_W'(W - 1);
  localparam logic [COL_W-1:0]  C_COL_MAX  = COL_W'(W - 3);
  localparam logic [ROWC_W-1:0] C_ROW_MAX  = ROWC_W'(H - 3);

  state_t                    r_state;
  logic [3:0]                r_idx;
  logic signed [DATA_W-1:0]  r_coef [10];
  logic [COL_W-1:0]          r_col;
  logic [ROWC_W-1:0]         r_row;

  logic signed [PROD_W-1:0]  r_prod [9];
  logic signed [ROW_W-1:0]   r_rsum [3];
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_v1, r_v2, r_v3;
  logic                      r_l1, r_l2, r_l3;

  logic signed [DATA_W-1:0]  w_pix [9];
  logic                      w_accept;
  logic                      w_last;
  logic [DATA_W-1:0]         w_sat;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_pix[i] = $signed(win_in[(8-i)*DATA_W +: DATA_W]);
    end
  end

  // Windows whose left column lies past W-3 wrap into the next row.
  assign w_accept = (r_state == ST_RUN) && win_valid && (r_col <= C_COL_MAX);
  assign w_last   = w_accept && (r_col == C_COL_MAX) && (r_row == C_ROW_MAX);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) begin
      r_prod[i] <= PROD_W'(w_pix[i]) * PROD_W'(r_coef[i]);
    end
    for (int r = 0; r < 3; r++) begin
      r_rsum[r] <= ROW_W'(r_prod[3*r]) + ROW_W'(r_prod[3*r+1]) + ROW_W'(r_prod[3*r+2]);
    end
    r_acc <= ACC_W'(r_rsum[0]) + ACC_W'(r_rsum[1]) + ACC_W'(r_rsum[2])
           + (ACC_W'(r_coef[9]) <<< FRAC);
  end

  conv1_sat_relu #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_sat_relu (
    .i_acc  (r_acc),
    .o_data (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_idx      <= '0;
      for (int i = 0; i < 10; i++) begin
        r_coef[i] <= '0;
      end
      r_col      <= '0;
      r_row      <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_l1       <= 1'b0;
      r_l2       <= 1'b0;
      r_l3       <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_v1       <= w_accept;
      r_l1       <= w_last;
      r_v2       <= r_v1;
      r_l2       <= r_l1;
      r_v3       <= r_v2;
      r_l3       <= r_l2;
      out_valid  <= r_v3;
      frame_done <= r_v3 && r_l3;
      if (r_v3) begin
        out_data <= w_sat;
      end

      case (r_state)
        ST_LOAD: begin
          if (w_wr) begin
            r_coef[r_idx] <= $signed(w_data);
            r_idx         <= r_idx + 4'd1;
            if (r_idx == 4'd9) begin
              r_state <= ST_RUN;
              ready   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (win_valid) begin
            if (r_col == C_COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == C_ROW_MAX) ? '0 : r_row + ROWC_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The frame's last window leaves stage 3 as frame_done is registered.
          if (r_v3 && r_l3) begin
            r_state <= ST_RUN;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
